trng_entropy_buffer: RTL and testbench
======================================

// Module: trng_entropy_buffer
// PURPOSE
//  Conditioning/buffering stage between trng_sampler's raw bit stream and the HSM AXI register file.
//  Runs continuous health tests (repetition count, adaptive proportion) on every sampled bit.
//  Packs accepted bits into 32-bit words and queues them in a FIFO the register file pops on RAND_OUT reads.
//  On health failure it locks out all output until software issues clear.
// PARAMETERS
//  FIFO_DEPTH    16    words in queue; power of 2, >=2
//  RCT_CUTOFF    32    consecutive identical bits that trip the repetition count test
//  APT_WINDOW    512   adaptive proportion window length in bits; power of 2
//  APT_CUTOFF    410   occurrences of window's first bit within one window that trip the APT
//  STARTUP_BITS  1024  bits health-tested and discarded after leaving IDLE
// PORTS
//  S_AXI_ACLK     in   1   clock
//  S_AXI_ARESETN  in   1   reset, asynchronous, active-low
//  enable         in   1   level; 1 = run, 0 = return to IDLE
//  clear          in   1   single-cycle pulse: flush and reset tests/flags/counters
//  bit_in         in   1   raw sampled bit
//  bit_valid      in   1   bit_in qualifier; one bit accepted per cycle high
//  pop            in   1   consume FIFO head (ignored when rd_valid=0)
//  rd_data        out  32  FIFO head word (first-word-fall-through); 0 when rd_valid=0
//  rd_valid       out  1   head valid: FIFO non-empty and state != FAIL
//  level          out  $clog2(FIFO_DEPTH)+1  words queued
//  state          out  2   IDLE=0 STARTUP=1 RUN=2 FAIL=3
//  rct_fail       out  1   sticky RCT failure
//  apt_fail       out  1   sticky APT failure
//  drop_cnt       out  16  words discarded because FIFO full; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; FIFO empty; level=0; rd_valid=0; rd_data=0; flags=0; drop_cnt=0; all internal counters 0.
//  Bit accept: bit_valid=1 and state in {STARTUP,RUN}. Bits in IDLE/FAIL are ignored entirely.
//  FSM (priority clear > fail > enable):
//   IDLE   : enable=1 -> STARTUP (startup counter, RCT, APT window restart).
//   STARTUP: after STARTUP_BITS accepted bits -> RUN; no words packed; enable=0 -> IDLE.
//   RUN    : packs words; enable=0 -> IDLE, partial word discarded, FIFO contents and flags kept.
//   any of STARTUP/RUN: a test trips on an accepted bit -> FAIL the next cycle; that bit is not packed.
//   FAIL   : FIFO flushed on entry; rd_valid=0; pops ignored; enable ignored; leave only via clear.
//  clear: next cycle FIFO empty, flags=0, drop_cnt=0, partial word/test counters zeroed; state -> STARTUP if enable else IDLE.
//  RCT: run counter of identical consecutive accepted bits (first bit = run 1); run reaching RCT_CUTOFF sets rct_fail.
//  APT: first accepted bit of each window is reference; count matches incl. itself; count reaching APT_CUTOFF sets apt_fail; window restarts after APT_WINDOW bits.
//  Tests run in STARTUP and RUN; run/window state persists across STARTUP->RUN.
//  Packing: shift = {shift[30:0], bit_in} (first bit ends in MSB); 5-bit counter; 32nd bit pushes {shift[30:0],bit_in} same edge, counter wraps 0.
//  Push latency: word visible on rd_data/rd_valid the cycle after the 32nd bit's accept edge.
//  Pop: pop && rd_valid advances head at clock edge; new head (or rd_valid=0) next cycle.
//  Full: push while full and no pop -> word dropped, drop_cnt+1 (saturating), head/level unchanged.
//  Push+pop same cycle: both take effect, level unchanged, including when full (no drop). Pop on empty ignored.
//  Pointers: log2(FIFO_DEPTH)-bit, natural wrap; level = wr_count - rd_count held as separate counter.
// STRUCTURE
//  trng_pkg: typedef enum logic [1:0] trng_state_t {IDLE,STARTUP,RUN,FAIL}; default cutoff/length localparams.
//  Sub-module trng_word_fifo: FWFT sync FIFO (push, pop, flush, full, empty, level, head); health FSM/packer in top.
// TESTING
//  1 enable, 1024+32 alternating bits starting 0 -> state RUN, rd_valid=1, rd_data=32'h55555555, level=1.
//  2 in RUN, 32 consecutive 1s -> rct_fail=1, state=FAIL, rd_valid=0, level=0; pop has no effect; clear -> flags 0.
//  3 512-bit window with 410 ones, no run >=32 -> apt_fail=1, FAIL; 409 ones -> no failure, window restarts.
//  4 fill 16 words, no pop, push 17th -> level=16, drop_cnt=1, head = 1st word; push+pop same cycle when full -> level=16, drop_cnt=1.
//  5 clear after 20 bits of a word -> level=0; next word requires 1024 startup + full 32 new bits.
//  6 assert S_AXI_ARESETN=0 mid-word, off clock edge -> all outputs at reset values before next edge; enable drop -> IDLE, FIFO kept.

Source files
------------

// File: rtl/trng_pkg.sv
// trng_pkg: state encoding and default health-test limits shared by the entropy buffer files
package trng_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, STARTUP = 2'd1, RUN = 2'd2, FAIL = 2'd3} trng_state_t;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int RCT_CUTOFF_DEF = 32;
  localparam int APT_WINDOW_DEF = 512;
  localparam int APT_CUTOFF_DEF = 410;
  localparam int STARTUP_BITS_DEF = 1024;
endpackage

// File: rtl/trng_entropy_buffer_if.sv
// trng_entropy_buffer_if: control, raw bit stream and read-side signals of the entropy buffer
interface trng_entropy_buffer_if import trng_pkg::*; #(parameter int FIFO_DEPTH = FIFO_DEPTH_DEF);
  logic enable, clear, bit_in, bit_valid, pop;
  logic [31:0] rd_data;
  logic rd_valid;
  logic [$clog2(FIFO_DEPTH):0] level;
  trng_state_t state;
  logic rct_fail, apt_fail;
  logic [15:0] drop_cnt;
  modport master (output enable, clear, bit_in, bit_valid, pop,
                  input rd_data, rd_valid, level, state, rct_fail, apt_fail, drop_cnt);
  modport slave (input enable, clear, bit_in, bit_valid, pop,
                 output rd_data, rd_valid, level, state, rct_fail, apt_fail, drop_cnt);
endinterface

// File: rtl/trng_word_fifo.sv
// trng_word_fifo: first-word-fall-through word queue with flush; level kept as its own counter
module trng_word_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 32
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESETN,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = level == '0;
  assign full = level == (PW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  // a pop in the same cycle frees the slot, so a push into a full queue still lands
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd_ptr];
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr + PW'(do_pop);
      level <= level + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  always_ff @(posedge S_AXI_ACLK)
    if (do_push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/trng_entropy_buffer.sv
// trng_entropy_buffer: health-tests raw TRNG bits, packs accepted bits into 32-bit words and
// queues them for the register file; a health failure locks out all output until clear
module trng_entropy_buffer import trng_pkg::*; #(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF,
  parameter int APT_WINDOW = APT_WINDOW_DEF,
  parameter int APT_CUTOFF = APT_CUTOFF_DEF,
  parameter int STARTUP_BITS = STARTUP_BITS_DEF
) (
  input logic S_AXI_ACLK,
  input logic S_AXI_ARESETN,
  trng_entropy_buffer_if.slave bus
);
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int AW = $clog2(APT_WINDOW);
  localparam int CW = $clog2(APT_CUTOFF + 1);
  localparam int SW = $clog2(STARTUP_BITS);
  localparam logic [RW-1:0] RCT_LIM = RW'(RCT_CUTOFF);
  localparam logic [CW-1:0] APT_LIM = CW'(APT_CUTOFF);
  localparam logic [SW-1:0] SU_LAST = SW'(STARTUP_BITS - 1);
  trng_state_t st;
  logic [RW-1:0] run, run_nx;
  logic [AW-1:0] win;
  logic [CW-1:0] match, match_nx;
  logic [SW-1:0] scnt;
  logic [4:0] pcnt;
  logic [31:0] shift, word, head;
  logic [15:0] drop_cnt;
  logic [$clog2(FIFO_DEPTH):0] level;
  logic prev, ref_bit, rct_fail, apt_fail;
  logic acc, rct_trip, apt_trip, trip, pk, push, rd_valid, pop_eff, flush, full, empty, drop;
  always_comb begin
    acc = bus.bit_valid && (st == STARTUP || st == RUN);
    run_nx = (run == '0 || bus.bit_in != prev) ? RW'(1) : run + 1'b1;
    match_nx = (win == '0) ? CW'(1) : match + CW'(bus.bit_in == ref_bit);
    rct_trip = acc && run_nx >= RCT_LIM;
    apt_trip = acc && match_nx >= APT_LIM;
    trip = !bus.clear && (rct_trip || apt_trip);
    pk = acc && st == RUN && !trip && !bus.clear;
    push = pk && pcnt == 5'd31;
    word = {shift[30:0], bus.bit_in};
    rd_valid = !empty && st != FAIL;
    pop_eff = bus.pop && rd_valid;
    flush = bus.clear || trip;
    drop = push && full && !pop_eff;
  end
  // test/pack counters are held at zero in IDLE so leaving IDLE always restarts them
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      st <= IDLE;
      run <= '0;
      win <= '0;
      match <= '0;
      scnt <= '0;
      pcnt <= '0;
      shift <= '0;
      prev <= 1'b0;
      ref_bit <= 1'b0;
      rct_fail <= 1'b0;
      apt_fail <= 1'b0;
      drop_cnt <= '0;
    end else if (bus.clear) begin
      st <= bus.enable ? STARTUP : IDLE;
      run <= '0;
      win <= '0;
      match <= '0;
      scnt <= '0;
      pcnt <= '0;
      rct_fail <= 1'b0;
      apt_fail <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (trip) begin
        st <= FAIL;
        rct_fail <= rct_fail | rct_trip;
        apt_fail <= apt_fail | apt_trip;
      end else if (st == IDLE) st <= bus.enable ? STARTUP : IDLE;
      else if (st != FAIL && !bus.enable) st <= IDLE;
      else if (st == STARTUP && acc && scnt == SU_LAST) st <= RUN;
      if (st == IDLE) begin
        run <= '0;
        win <= '0;
        match <= '0;
        scnt <= '0;
        pcnt <= '0;
      end else if (acc) begin
        prev <= bus.bit_in;
        run <= run_nx;
        win <= win + 1'b1;
        match <= match_nx;
        if (win == '0) ref_bit <= bus.bit_in;
        if (st == STARTUP) scnt <= scnt + 1'b1;
        if (pk) begin
          shift <= word;
          pcnt <= pcnt + 1'b1;
        end
      end
    end
  trng_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN), .push(push), .pop(pop_eff),
    .flush(flush), .din(word), .head(head), .full(full), .empty(empty), .level(level)
  );
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data = rd_valid ? head : '0;
  assign bus.level = level;
  assign bus.state = st;
  assign bus.rct_fail = rct_fail;
  assign bus.apt_fail = apt_fail;
  assign bus.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_trng_entropy_buffer.sv
// tb_trng_entropy_buffer: directed and randomized checks of the entropy buffer against a
// reference model built on the full history of accepted bits
module tb_trng_entropy_buffer;
  import trng_pkg::*;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  trng_entropy_buffer_if #(.FIFO_DEPTH(16)) bus();
  trng_entropy_buffer #(.FIFO_DEPTH(16), .RCT_CUTOFF(32), .APT_WINDOW(512), .APT_CUTOFF(410),
    .STARTUP_BITS(1024)) dut (.S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn), .bus(bus));
  int n_chk = 0, n_fail = 0;
  int m_st, m_drop;
  bit m_rf, m_af;
  bit m_hist[$];
  bit m_w[$];
  logic [31:0] m_q[$];
  logic [31:0] gen[$];
  function automatic void model_reset();
    m_st = 0; m_drop = 0; m_rf = 0; m_af = 0;
    m_hist.delete(); m_w.delete(); m_q.delete();
  endfunction
  function automatic void model_edge(bit en, bit clr, bit b, bit bv, bit pp);
    bit rdv;
    rdv = m_q.size() > 0 && m_st != 3;
    if (clr) begin
      model_reset();
      m_st = en ? 1 : 0;
      return;
    end
    if (m_st == 3) return;
    if (pp && rdv) void'(m_q.pop_front());
    if (m_st == 0) begin
      m_st = en ? 1 : 0;
      return;
    end
    if (bv) begin
      int n, run, ws, cnt;
      logic [31:0] w;
      m_hist.push_back(b);
      n = m_hist.size();
      run = 0;
      while (run < n && m_hist[n-1-run] == b) run++;
      ws = ((n - 1) / 512) * 512;
      cnt = 0;
      for (int i = ws; i < n; i++) if (m_hist[i] == m_hist[ws]) cnt++;
      if (run >= 32 || cnt >= 410) begin
        m_rf = m_rf | (run >= 32);
        m_af = m_af | (cnt >= 410);
        m_st = 3;
        m_q.delete();
        return;
      end
      if (m_st == 2) begin
        m_w.push_back(b);
        if (m_w.size() == 32) begin
          w = '0;
          foreach (m_w[i]) w = {w[30:0], m_w[i]};
          m_w.delete();
          if (m_q.size() < 16) m_q.push_back(w);
          else if (m_drop < 65535) m_drop++;
        end
      end else if (n == 1024 && en) m_st = 2;
    end
    if (!en) begin
      m_st = 0;
      m_hist.delete();
      m_w.delete();
    end
  endfunction
  task automatic step(input bit en, input bit clr, input bit b, input bit bv, input bit pp);
    bus.enable = en; bus.clear = clr; bus.bit_in = b; bus.bit_valid = bv; bus.pop = pp;
    @(posedge clk);
    model_edge(en, clr, b, bv, pp);
    #1;
  endtask
  task automatic feed_word(input logic [31:0] w, input bit last_pop);
    for (int k = 31; k >= 0; k--) step(1, 0, w[k], 1, k == 0 && last_pop);
  endtask
  task automatic test_reset();
    rstn = 0;
    bus.enable = 0; bus.clear = 0; bus.bit_in = 0; bus.bit_valid = 0; bus.pop = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_chk++; if (bus.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    n_chk++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    n_chk++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    n_chk++; if (bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
    n_chk++; if ({bus.rct_fail, bus.apt_fail} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {bus.rct_fail, bus.apt_fail}); end
    n_chk++; if (bus.drop_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", bus.drop_cnt); end
    rstn = 1;
  endtask
  task automatic test_startup();
    step(1, 0, 0, 0, 0);
    n_chk++; if (bus.state !== STARTUP) begin n_fail++; $display("FAIL startup_enter: got %0d want 1", bus.state); end
    for (int i = 0; i < 1056; i++) begin
      step(1, 0, i[0], 1, 0);
      if (i == 1022) begin
        n_chk++; if (bus.state !== STARTUP) begin n_fail++; $display("FAIL startup_hold: got %0d want 1", bus.state); end
      end
      if (i == 1023) begin
        n_chk++; if (bus.level !== 5'd0 || bus.state !== RUN) begin n_fail++; $display("FAIL startup_to_run: got state %0d level %0d want 2/0", bus.state, bus.level); end
      end
    end
    n_chk++; if (bus.state !== RUN) begin n_fail++; $display("FAIL startup_state: got %0d want 2", bus.state); end
    n_chk++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL startup_rd_valid: got %b want 1", bus.rd_valid); end
    n_chk++; if (bus.rd_data !== 32'h55555555) begin n_fail++; $display("FAIL startup_word: got %h want 55555555", bus.rd_data); end
    n_chk++; if (bus.level !== 5'd1) begin n_fail++; $display("FAIL startup_level: got %0d want 1", bus.level); end
  endtask
  task automatic test_rct();
    for (int i = 0; i < 32; i++) step(1, 0, 1, 1, 0);
    n_chk++; if (bus.rct_fail !== 1'b1 || bus.apt_fail !== 1'b0) begin n_fail++; $display("FAIL rct_flags: got %b%b want 10", bus.rct_fail, bus.apt_fail); end
    n_chk++; if (bus.state !== FAIL) begin n_fail++; $display("FAIL rct_state: got %0d want 3", bus.state); end
    n_chk++; if (bus.rd_valid !== 1'b0 || bus.level !== 5'd0 || bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL rct_lockout: got valid %b level %0d data %h want 0/0/0", bus.rd_valid, bus.level, bus.rd_data); end
    step(0, 0, 0, 1, 1);
    n_chk++; if (bus.state !== FAIL || bus.level !== 5'd0) begin n_fail++; $display("FAIL rct_sticky: got state %0d level %0d want 3/0", bus.state, bus.level); end
    step(1, 1, 0, 0, 0);
    n_chk++; if ({bus.rct_fail, bus.apt_fail} !== 2'b00 || bus.state !== STARTUP) begin n_fail++; $display("FAIL rct_clear: got flags %b state %0d want 00/1", {bus.rct_fail, bus.apt_fail}, bus.state); end
  endtask
  task automatic test_apt();
    for (int i = 0; i < 512; i++) step(1, 0, !(i % 5 == 4 || i == 511), 1, 0);
    n_chk++; if (bus.apt_fail !== 1'b0 || bus.state !== STARTUP) begin n_fail++; $display("FAIL apt_409: got apt %b state %0d want 0/1", bus.apt_fail, bus.state); end
    for (int i = 0; i < 512; i++) step(1, 0, !(i % 5 == 4), 1, 0);
    n_chk++; if (bus.apt_fail !== 1'b1 || bus.rct_fail !== 1'b0) begin n_fail++; $display("FAIL apt_410: got apt %b rct %b want 1/0", bus.apt_fail, bus.rct_fail); end
    n_chk++; if (bus.state !== FAIL) begin n_fail++; $display("FAIL apt_state: got %0d want 3", bus.state); end
    step(1, 1, 0, 0, 0);
    n_chk++; if (bus.apt_fail !== 1'b0 || bus.state !== STARTUP) begin n_fail++; $display("FAIL apt_clear: got apt %b state %0d want 0/1", bus.apt_fail, bus.state); end
  endtask
  task automatic test_full();
    logic [31:0] w;
    for (int i = 0; i < 1024; i++) step(1, 0, $urandom_range(0, 1), 1, 0);
    gen.delete();
    for (int j = 0; j < 17; j++) begin
      w = $urandom;
      gen.push_back(w);
      feed_word(w, 0);
    end
    n_chk++; if (bus.level !== 5'd16) begin n_fail++; $display("FAIL full_level: got %0d want 16", bus.level); end
    n_chk++; if (bus.drop_cnt !== 16'd1) begin n_fail++; $display("FAIL full_drop: got %0d want 1", bus.drop_cnt); end
    n_chk++; if (bus.rd_data !== gen[0]) begin n_fail++; $display("FAIL full_head: got %h want %h", bus.rd_data, gen[0]); end
    w = $urandom;
    feed_word(w, 1);
    n_chk++; if (bus.level !== 5'd16 || bus.drop_cnt !== 16'd1) begin n_fail++; $display("FAIL full_push_pop: got level %0d drop %0d want 16/1", bus.level, bus.drop_cnt); end
    n_chk++; if (bus.rd_data !== gen[1]) begin n_fail++; $display("FAIL full_next_head: got %h want %h", bus.rd_data, gen[1]); end
  endtask
  task automatic test_clear_mid();
    logic [31:0] w;
    for (int i = 0; i < 20; i++) step(1, 0, $urandom_range(0, 1), 1, 0);
    step(1, 1, 1, 1, 0);
    n_chk++; if (bus.level !== 5'd0 || bus.rd_valid !== 1'b0 || bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL clear_flush: got level %0d valid %b drop %0d want 0/0/0", bus.level, bus.rd_valid, bus.drop_cnt); end
    n_chk++; if (bus.state !== STARTUP) begin n_fail++; $display("FAIL clear_state: got %0d want 1", bus.state); end
    for (int i = 0; i < 1024; i++) step(1, 0, $urandom_range(0, 1), 1, 0);
    w = $urandom;
    for (int k = 31; k >= 1; k--) step(1, 0, w[k], 1, 0);
    n_chk++; if (bus.level !== 5'd0) begin n_fail++; $display("FAIL clear_partial: got level %0d want 0", bus.level); end
    step(1, 0, w[0], 1, 0);
    n_chk++; if (bus.level !== 5'd1 || bus.rd_data !== w) begin n_fail++; $display("FAIL clear_new_word: got level %0d data %h want 1/%h", bus.level, bus.rd_data, w); end
  endtask
  task automatic test_async_reset();
    logic [31:0] w0, w1;
    for (int i = 0; i < 10; i++) step(1, 0, $urandom_range(0, 1), 1, 0);
    #2 rstn = 0;
    #1;
    n_chk++; if (bus.state !== IDLE || bus.level !== 5'd0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0) begin n_fail++; $display("FAIL async_reset: got state %0d level %0d valid %b data %h want 0", bus.state, bus.level, bus.rd_valid, bus.rd_data); end
    model_reset();
    #1 rstn = 1;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 1024; i++) step(1, 0, $urandom_range(0, 1), 1, 0);
    w0 = $urandom;
    w1 = $urandom;
    feed_word(w0, 0);
    feed_word(w1, 0);
    step(0, 0, 1, 1, 0);
    n_chk++; if (bus.state !== IDLE) begin n_fail++; $display("FAIL disable_state: got %0d want 0", bus.state); end
    n_chk++; if (bus.level !== 5'd2 || bus.rd_valid !== 1'b1 || bus.rd_data !== w0) begin n_fail++; $display("FAIL disable_keep: got level %0d valid %b data %h want 2/1/%h", bus.level, bus.rd_valid, bus.rd_data, w0); end
  endtask
  task automatic test_random();
    bit b = 0;
    for (int c = 0; c < 4500; c++) begin
      if (c < 3000) b = $urandom_range(0, 1);
      else if ($urandom_range(0, 39) == 0) b = !b;
      step($urandom_range(0, 2999) != 0, $urandom_range(0, c < 3000 ? 1999 : 199) == 0, b,
           $urandom_range(0, 9) < 8, $urandom_range(0, 59) == 0);
      n_chk++; if (bus.state !== 2'(m_st)) begin n_fail++; $display("FAIL rand_state c=%0d: got %0d want %0d", c, bus.state, m_st); end
      n_chk++; if (bus.level !== 5'(m_q.size())) begin n_fail++; $display("FAIL rand_level c=%0d: got %0d want %0d", c, bus.level, m_q.size()); end
      n_chk++; if (bus.rd_valid !== (m_q.size() > 0 && m_st != 3)) begin n_fail++; $display("FAIL rand_valid c=%0d: got %b", c, bus.rd_valid); end
      n_chk++; if (bus.rd_data !== ((m_q.size() > 0 && m_st != 3) ? m_q[0] : 32'h0)) begin n_fail++; $display("FAIL rand_data c=%0d: got %h", c, bus.rd_data); end
      n_chk++; if ({bus.rct_fail, bus.apt_fail} !== {m_rf, m_af}) begin n_fail++; $display("FAIL rand_flags c=%0d: got %b want %b", c, {bus.rct_fail, bus.apt_fail}, {m_rf, m_af}); end
      n_chk++; if (bus.drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL rand_drop c=%0d: got %0d want %0d", c, bus.drop_cnt, m_drop); end
    end
  endtask
  initial begin
    test_reset();
    test_startup();
    test_rct();
    test_apt();
    test_full();
    test_clear_mid();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
